// File: rtl/nvdla_apb2csb_bridge.sv
// APB3-to-CSB bridge with registered CSB request, optional non-posted writes,
// response timeout and address window/alignment checking.
module nvdla_apb2csb_bridge #(
   parameter int unsigned PADDR_W    = 32,
   parameter int unsigned CSB_AW     = 16,
   parameter int unsigned BASE_ADDR  = 0,
   parameter bit          NPOSTED_WR = 1'b0,
   parameter int unsigned TIMEOUT    = 1024,
   parameter logic [31:0] ERR_DATA   = 32'hDEAD_C5B0
) (
   input  logic                pclk,
   input  logic                prstn,
   input  logic                psel,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [PADDR_W-1:0]  paddr,
   input  logic [31:0]         pwdata,
   output logic [31:0]         prdata,
   output logic                pready,
   output logic                pslverr,
   output logic                csb2nvdla_valid,
   input  logic                csb2nvdla_ready,
   output logic [CSB_AW-1:0]   csb2nvdla_addr,
   output logic [31:0]         csb2nvdla_wdat,
   output logic                csb2nvdla_write,
   output logic                csb2nvdla_nposted,
   input  logic                nvdla2csb_valid,
   input  logic [31:0]         nvdla2csb_data,
   input  logic                nvdla2csb_wr_complete,
   output logic                csb_timeout
);

   localparam int unsigned UW   = PADDR_W - CSB_AW - 2;
   localparam logic [UW-1:0] BASE = UW'(BASE_ADDR);
   localparam logic [15:0]   TMAX = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t      state;
   logic [15:0] cnt;
   logic        addr_bad;

   assign addr_bad = (paddr[1:0] != 2'b00) || (paddr[PADDR_W-1:CSB_AW+2] != BASE);

   always_ff @(posedge pclk) begin
      if (!prstn) begin
         state             <= S_IDLE;
         cnt               <= '0;
         prdata            <= '0;
         pready            <= 1'b0;
         pslverr           <= 1'b0;
         csb2nvdla_valid   <= 1'b0;
         csb2nvdla_addr    <= '0;
         csb2nvdla_wdat    <= '0;
         csb2nvdla_write   <= 1'b0;
         csb2nvdla_nposted <= 1'b0;
         csb_timeout       <= 1'b0;
      end else begin
         pready      <= 1'b0;
         pslverr     <= 1'b0;
         csb_timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (psel && penable) begin
                  csb2nvdla_addr    <= paddr[CSB_AW+1:2];
                  csb2nvdla_wdat    <= pwdata;
                  csb2nvdla_write   <= pwrite;
                  csb2nvdla_nposted <= NPOSTED_WR && pwrite;
                  cnt               <= '0;
                  if (addr_bad) begin
                     state   <= S_DONE;
                     pready  <= 1'b1;
                     pslverr <= 1'b1;
                     if (!pwrite) prdata <= ERR_DATA;
                  end else begin
                     state           <= S_REQ;
                     csb2nvdla_valid <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               cnt <= cnt + 16'd1;
               // An accept on the timeout cycle takes priority over the error.
               if (csb2nvdla_ready) begin
                  csb2nvdla_valid <= 1'b0;
                  if (csb2nvdla_write && !csb2nvdla_nposted) begin
                     state  <= S_DONE;
                     pready <= 1'b1;
                  end else begin
                     state <= S_WAIT;
                  end
               end else if (cnt == TMAX) begin
                  csb2nvdla_valid <= 1'b0;
                  state           <= S_DONE;
                  pready          <= 1'b1;
                  pslverr         <= 1'b1;
                  csb_timeout     <= 1'b1;
                  if (!csb2nvdla_write) prdata <= ERR_DATA;
               end
            end
            S_WAIT: begin
               cnt <= cnt + 16'd1;
               if (!csb2nvdla_write && nvdla2csb_valid) begin
                  prdata <= nvdla2csb_data;
                  state  <= S_DONE;
                  pready <= 1'b1;
               end else if (csb2nvdla_write && nvdla2csb_wr_complete) begin
                  state  <= S_DONE;
                  pready <= 1'b1;
               end else if (cnt == TMAX) begin
                  state       <= S_DONE;
                  pready      <= 1'b1;
                  pslverr     <= 1'b1;
                  csb_timeout <= 1'b1;
                  if (!csb2nvdla_write) prdata <= ERR_DATA;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nvdla_apb2csb_bridge.sv
// Bench for nvdla_apb2csb_bridge: instance a is posted (TIMEOUT=16), instance b non-posted.
module tb_nvdla_apb2csb_bridge;

   logic        pclk = 1'b0;
   logic        prstn, psel_a, psel_b, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic        csb_ready, rsp_valid, wr_complete;
   logic [31:0] rsp_data;

   logic [31:0] prdata_a, prdata_b, wdat_a, wdat_b;
   logic [15:0] addr_a, addr_b;
   logic        pready_a, pready_b, pslverr_a, pslverr_b;
   logic        valid_a, valid_b, write_a, write_b, np_a, np_b, to_a, to_b;

   int tests = 0;
   int fails = 0;

   typedef struct { logic is_read; logic [31:0] data; logic err; int lat; } exp_t;
   exp_t sb[$];

   int          vcnt_a = 0, vcnt_b = 0, tocnt_a = 0;
   logic [15:0] cap_addr_a, cap_addr_b;
   logic [31:0] cap_wdat_a;
   logic        cap_np_a, cap_np_b;

   always #5 pclk = ~pclk;

   nvdla_apb2csb_bridge #(.TIMEOUT(16)) dut_a (
      .pclk(pclk), .prstn(prstn), .psel(psel_a), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a),
      .csb2nvdla_valid(valid_a), .csb2nvdla_ready(csb_ready), .csb2nvdla_addr(addr_a),
      .csb2nvdla_wdat(wdat_a), .csb2nvdla_write(write_a), .csb2nvdla_nposted(np_a),
      .nvdla2csb_valid(rsp_valid), .nvdla2csb_data(rsp_data),
      .nvdla2csb_wr_complete(wr_complete), .csb_timeout(to_a));

   nvdla_apb2csb_bridge #(.TIMEOUT(16), .NPOSTED_WR(1'b1)) dut_b (
      .pclk(pclk), .prstn(prstn), .psel(psel_b), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b),
      .csb2nvdla_valid(valid_b), .csb2nvdla_ready(csb_ready), .csb2nvdla_addr(addr_b),
      .csb2nvdla_wdat(wdat_b), .csb2nvdla_write(write_b), .csb2nvdla_nposted(np_b),
      .nvdla2csb_valid(rsp_valid), .nvdla2csb_data(rsp_data),
      .nvdla2csb_wr_complete(wr_complete), .csb_timeout(to_b));

   always @(negedge pclk) begin
      if (valid_a) vcnt_a <= vcnt_a + 1;
      if (valid_b) vcnt_b <= vcnt_b + 1;
      if (to_a)    tocnt_a <= tocnt_a + 1;
   end

   always @(posedge pclk) begin
      if (valid_a && csb_ready) begin
         cap_addr_a <= addr_a; cap_wdat_a <= wdat_a; cap_np_a <= np_a;
      end
      if (valid_b && csb_ready) begin
         cap_addr_b <= addr_b; cap_np_b <= np_b;
      end
   end

   // Setup then access phase; returns 1 ns into access cycle 0.
   task automatic apb_access(input bit b, input bit wr, input logic [31:0] a, input logic [31:0] d);
      @(posedge pclk); #1;
      psel_a = !b; psel_b = b; pwrite = wr; paddr = a; pwdata = d; penable = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
   endtask

   task automatic apb_end();
      @(posedge pclk); #1;
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
   endtask

   task automatic wait_pready(input bit b, input int bound, output int lat);
      lat = -1;
      for (int k = 0; k <= bound; k++) begin
         @(negedge pclk);
         if (b ? pready_b : pready_a) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      prstn = 1'b0; psel_a = 0; psel_b = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
      csb_ready = 0; rsp_valid = 0; rsp_data = '0; wr_complete = 0;
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      tests++;
      if ({pready_a, pslverr_a, valid_a, write_a, np_a, to_a, prdata_a, addr_a, wdat_a} !== '0) begin
         fails++;
         $display("FAIL reset_a: got rdy=%b err=%b v=%b prdata=%h addr=%h, want all 0",
                  pready_a, pslverr_a, valid_a, prdata_a, addr_a);
      end
      tests++;
      if ({pready_b, valid_b, np_b, prdata_b} !== '0) begin
         fails++;
         $display("FAIL reset_b: got rdy=%b v=%b np=%b prdata=%h, want all 0", pready_b, valid_b, np_b, prdata_b);
      end
      @(posedge pclk); #1 prstn = 1'b1;
   endtask

   task automatic test_posted_write();
      int lat, v0;
      exp_t e;
      csb_ready = 1'b1;
      v0 = vcnt_a;
      apb_access(0, 1, 32'h0000_1004, 32'h1234_5678);
      sb.push_back('{1'b0, 32'h0, 1'b0, 2});
      wait_pready(0, 40, lat);
      e = sb.pop_front();
      tests++;
      if (lat !== e.lat || pslverr_a !== e.err) begin
         fails++;
         $display("FAIL posted_write: got lat=%0d err=%b, want lat=%0d err=%b", lat, pslverr_a, e.lat, e.err);
      end
      apb_end();
      @(negedge pclk);
      tests++;
      if (vcnt_a - v0 !== 1 || cap_addr_a !== 16'h0401 || cap_wdat_a !== 32'h1234_5678 || cap_np_a !== 1'b0) begin
         fails++;
         $display("FAIL posted_req: got vcyc=%0d addr=%h wdat=%h np=%b, want 1 0401 12345678 0",
                  vcnt_a - v0, cap_addr_a, cap_wdat_a, cap_np_a);
      end
      tests++;
      if (pready_a !== 1'b0) begin
         fails++;
         $display("FAIL pready_pulse: got %b want 0", pready_a);
      end
   endtask

   task automatic test_read_stall();
      int lat;
      exp_t e;
      csb_ready = 1'b0;
      apb_access(0, 0, 32'h0000_0A5C, 32'h0);
      sb.push_back('{1'b1, 32'hA5A5_0F0F, 1'b0, 10});
      fork
         wait_pready(0, 40, lat);
         begin
            @(negedge pclk);
            for (int k = 1; k <= 5; k++) begin
               @(negedge pclk);
               tests++;
               if (valid_a !== 1'b1 || addr_a !== 16'h0297) begin
                  fails++;
                  $display("FAIL stall_hold c%0d: got v=%b addr=%h, want 1 0297", k, valid_a, addr_a);
               end
            end
            @(posedge pclk); #1 csb_ready = 1'b1;
            @(posedge pclk); #1 csb_ready = 1'b0;
            repeat (2) @(posedge pclk);
            #1 rsp_valid = 1'b1; rsp_data = 32'hA5A5_0F0F;
            @(posedge pclk); #1 rsp_valid = 1'b0;
         end
      join
      e = sb.pop_front();
      tests++;
      if (lat !== e.lat || pslverr_a !== e.err || prdata_a !== e.data) begin
         fails++;
         $display("FAIL read_stall: got lat=%0d err=%b data=%h, want lat=%0d err=%b data=%h",
                  lat, pslverr_a, prdata_a, e.lat, e.err, e.data);
      end
      apb_end();
   endtask

   task automatic test_timeout();
      int lat, t0, v0;
      exp_t e;
      // Accepted but no response: times out in WAIT.
      csb_ready = 1'b1;
      t0 = tocnt_a;
      apb_access(0, 0, 32'h0000_0020, 32'h0);
      sb.push_back('{1'b1, 32'hDEAD_C5B0, 1'b1, 17});
      wait_pready(0, 40, lat);
      e = sb.pop_front();
      tests++;
      if (lat !== e.lat || pslverr_a !== e.err || prdata_a !== e.data) begin
         fails++;
         $display("FAIL timeout_wait: got lat=%0d err=%b data=%h, want lat=%0d err=%b data=%h",
                  lat, pslverr_a, prdata_a, e.lat, e.err, e.data);
      end
      apb_end();
      #1 rsp_valid = 1'b1; rsp_data = 32'h1111_1111;
      repeat (2) @(posedge pclk);
      #1 rsp_valid = 1'b0;
      @(negedge pclk);
      tests++;
      if (tocnt_a - t0 !== 1 || prdata_a !== 32'hDEAD_C5B0 || pready_a !== 1'b0) begin
         fails++;
         $display("FAIL late_rsp: got pulses=%0d data=%h rdy=%b, want 1 deadc5b0 0", tocnt_a - t0, prdata_a, pready_a);
      end
      // Never accepted: times out in REQ, valid dropped.
      csb_ready = 1'b0;
      v0 = vcnt_a;
      apb_access(0, 0, 32'h0000_0024, 32'h0);
      sb.push_back('{1'b1, 32'hDEAD_C5B0, 1'b1, 17});
      wait_pready(0, 40, lat);
      e = sb.pop_front();
      tests++;
      if (lat !== e.lat || pslverr_a !== e.err || prdata_a !== e.data || valid_a !== 1'b0 || vcnt_a - v0 !== 16) begin
         fails++;
         $display("FAIL timeout_req: got lat=%0d err=%b data=%h v=%b vcyc=%0d, want lat=%0d err=%b data=%h v=0 vcyc=16",
                  lat, pslverr_a, prdata_a, valid_a, vcnt_a - v0, e.lat, e.err, e.data);
      end
      apb_end();
      // Response on the timeout cycle wins.
      csb_ready = 1'b1;
      t0 = tocnt_a;
      apb_access(0, 0, 32'h0000_0028, 32'h0);
      sb.push_back('{1'b1, 32'h5A5A_1234, 1'b0, 17});
      fork
         wait_pready(0, 40, lat);
         begin
            repeat (16) @(posedge pclk);
            #1 rsp_valid = 1'b1; rsp_data = 32'h5A5A_1234;
            @(posedge pclk); #1 rsp_valid = 1'b0;
         end
      join
      e = sb.pop_front();
      tests++;
      if (lat !== e.lat || pslverr_a !== e.err || prdata_a !== e.data || tocnt_a - t0 !== 0) begin
         fails++;
         $display("FAIL rsp_vs_timeout: got lat=%0d err=%b data=%h pulses=%0d, want lat=%0d err=%b data=%h pulses=0",
                  lat, pslverr_a, prdata_a, tocnt_a - t0, e.lat, e.err, e.data);
      end
      apb_end();
   endtask

   task automatic test_addr_check();
      int lat, v0;
      exp_t e;
      csb_ready = 1'b1;
      v0 = vcnt_a;
      apb_access(0, 0, 32'h0004_0002, 32'h0);
      sb.push_back('{1'b1, 32'hDEAD_C5B0, 1'b1, 1});
      wait_pready(0, 40, lat);
      e = sb.pop_front();
      tests++;
      if (lat !== e.lat || pslverr_a !== e.err || prdata_a !== e.data) begin
         fails++;
         $display("FAIL bad_addr_rd: got lat=%0d err=%b data=%h, want lat=%0d err=%b data=%h",
                  lat, pslverr_a, prdata_a, e.lat, e.err, e.data);
      end
      apb_end();
      apb_access(0, 1, 32'h0008_0000, 32'hCAFE_0000);
      sb.push_back('{1'b0, 32'h0, 1'b1, 1});
      wait_pready(0, 40, lat);
      e = sb.pop_front();
      tests++;
      if (lat !== e.lat || pslverr_a !== e.err) begin
         fails++;
         $display("FAIL window_wr: got lat=%0d err=%b, want lat=%0d err=%b", lat, pslverr_a, e.lat, e.err);
      end
      apb_end();
      @(negedge pclk);
      tests++;
      if (vcnt_a - v0 !== 0) begin
         fails++;
         $display("FAIL bad_addr_noreq: got vcyc=%0d want 0", vcnt_a - v0);
      end
   endtask

   task automatic test_nposted_write();
      int lat;
      exp_t e;
      csb_ready = 1'b1;
      apb_access(1, 1, 32'h0000_0040, 32'h0BAD_F00D);
      sb.push_back('{1'b0, 32'h0, 1'b0, 6});
      fork
         wait_pready(1, 40, lat);
         begin
            repeat (3) @(posedge pclk);
            #1 rsp_valid = 1'b1; rsp_data = 32'h7777_7777;
            @(posedge pclk); #1 rsp_valid = 1'b0;
            @(posedge pclk); #1 wr_complete = 1'b1;
            @(posedge pclk); #1 wr_complete = 1'b0;
         end
      join
      e = sb.pop_front();
      tests++;
      if (lat !== e.lat || pslverr_b !== e.err || cap_np_b !== 1'b1 || cap_addr_b !== 16'h0010) begin
         fails++;
         $display("FAIL nposted_wr: got lat=%0d err=%b np=%b addr=%h, want lat=%0d err=%b np=1 addr=0010",
                  lat, pslverr_b, cap_np_b, cap_addr_b, e.lat, e.err);
      end
      tests++;
      if (prdata_b !== 32'h0) begin
         fails++;
         $display("FAIL stray_rsp: got prdata=%h want 00000000", prdata_b);
      end
      apb_end();
   endtask

   task automatic test_reset_in_wait();
      int lat, seen;
      exp_t e;
      csb_ready = 1'b1;
      apb_access(0, 0, 32'h0000_0100, 32'h0);
      repeat (4) @(posedge pclk);
      #1 prstn = 1'b0; psel_a = 1'b0; penable = 1'b0;
      @(posedge pclk); #1 prstn = 1'b1;
      @(negedge pclk);
      tests++;
      if ({pready_a, pslverr_a, valid_a, write_a, np_a, to_a, prdata_a, addr_a, wdat_a} !== '0) begin
         fails++;
         $display("FAIL reset_wait: got rdy=%b err=%b v=%b prdata=%h addr=%h, want all 0",
                  pready_a, pslverr_a, valid_a, prdata_a, addr_a);
      end
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge pclk);
         if (pready_a) seen++;
      end
      tests++;
      if (seen !== 0) begin
         fails++;
         $display("FAIL abandoned: got %0d pready cycles want 0", seen);
      end
      apb_access(0, 0, 32'h0000_0104, 32'h0);
      sb.push_back('{1'b1, 32'h0123_4567, 1'b0, 3});
      fork
         wait_pready(0, 40, lat);
         begin
            repeat (2) @(posedge pclk);
            #1 rsp_valid = 1'b1; rsp_data = 32'h0123_4567;
            @(posedge pclk); #1 rsp_valid = 1'b0;
         end
      join
      e = sb.pop_front();
      tests++;
      if (lat !== e.lat || pslverr_a !== e.err || prdata_a !== e.data) begin
         fails++;
         $display("FAIL read_after_rst: got lat=%0d err=%b data=%h, want lat=%0d err=%b data=%h",
                  lat, pslverr_a, prdata_a, e.lat, e.err, e.data);
      end
      apb_end();
   endtask

   initial begin
      test_reset();
      test_posted_write();
      test_read_stall();
      test_timeout();
      test_addr_check();
      test_nposted_write();
      test_reset_in_wait();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
